// File: rtl/booth_wallace_cla.sv
// booth_wallace_cla: signed radix-4 Booth / Wallace / CLA multiplier; define BOOTH_WALLACE_CLA_PIPE_EN for a tree-to-CLA register stage
module booth_wallace_cla #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);
  localparam int P = 2 * WIDTH;
  localparam int N = WIDTH / 2;
  localparam int NG = P / 4;
  function automatic int cnt(input int l);
    int n;
    n = N + 1;
    for (int i = 0; i < l; i++) n = n - n / 3;
    return n;
  endfunction
  function automatic int depth();
    int n, d;
    n = N + 1;
    d = 0;
    while (n > 2) begin
      n = n - n / 3;
      d++;
    end
    return d;
  endfunction
  localparam int D = depth();
  logic [WIDTH:0] bx;
  logic [P-1:0] ae;
  logic [P-1:0] pp [N];
  logic [P-1:0] cor;
  logic [2:0] t;
  logic neg;
  logic [P-1:0] mag;
  logic [P-1:0] tr [D+1][N+1];
  assign bx = {multiplier, 1'b0};
  assign ae = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
  always_comb begin
    cor = '0;
    t = '0;
    neg = 1'b0;
    mag = '0;
    for (int i = 0; i < N; i++) begin
      t = bx[2*i +: 3];
      neg = t[2] & ~(t[1] & t[0]);
      mag = (t[1] ^ t[0]) ? ae : ((t == 3'b011) || (t == 3'b100)) ? ae << 1 : '0;
      pp[i] = (neg ? ~mag : mag) << (2 * i);
      cor[2*i] = neg;
    end
  end
  for (genvar j = 0; j < N; j++) begin : g_pp
    assign tr[0][j] = pp[j];
  end
  assign tr[0][N] = cor;
  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int n = cnt(l);
    localparam int k = n / 3;
    for (genvar o = 0; o <= N; o++) begin : g_out
      if (o < 2 * k && o % 2 == 0) begin : g_sum
        assign tr[l+1][o] = tr[l][3*(o/2)] ^ tr[l][3*(o/2)+1] ^ tr[l][3*(o/2)+2];
      end else if (o < 2 * k) begin : g_car
        assign tr[l+1][o] = ((tr[l][3*(o/2)] & tr[l][3*(o/2)+1]) |
                             (tr[l][3*(o/2)] & tr[l][3*(o/2)+2]) |
                             (tr[l][3*(o/2)+1] & tr[l][3*(o/2)+2])) << 1;
      end else if (o < n - k) begin : g_pass
        assign tr[l+1][o] = tr[l][o+k];
      end else begin : g_zero
        assign tr[l+1][o] = '0;
      end
    end
  end
  logic [P-1:0] x, y, g, p, c, s;
  logic [NG-1:0] gg, gp, gc;
  logic tm;
  logic vin;
`ifdef BOOTH_WALLACE_CLA_PIPE_EN
  logic [P-1:0] s_q, c_q;
  logic v_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        s_q <= tr[D][0];
        c_q <= tr[D][1];
      end
    end
  end
  assign x = s_q;
  assign y = c_q;
  assign vin = v_q;
`else
  assign x = tr[D][0];
  assign y = tr[D][1];
  assign vin = in_valid;
`endif
  always_comb begin
    g = x & y;
    p = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c = '0;
    tm = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (&p[4*k+1 +: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    for (int k = 1; k < NG; k++) begin
      for (int j = 0; j < k; j++) begin
        tm = gg[j];
        for (int m = j + 1; m < k; m++) tm = tm & gp[m];
        gc[k] = gc[k] | tm;
      end
    end
    for (int k = 0; k < NG; k++) begin
      c[4*k] = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (&p[4*k +: 3] & gc[k]);
    end
    s = p ^ c;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vin;
      if (vin) product <= s;
    end
  end
endmodule

// File: tb/tb_booth_wallace_cla.sv
// tb_booth_wallace_cla: random and directed checks of booth_wallace_cla against an ideal delayed signed product
module tb_booth_wallace_cla;
  localparam int W = 16;
`ifdef BOOTH_WALLACE_CLA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b1;
  logic [W-1:0] multiplicand = 16'd5;
  logic [W-1:0] multiplier = 16'd7;
  logic out_valid;
  logic [2*W-1:0] product;
  int vectors = 0;
  int miscompares = 0;
  bit seen = 1'b0;
  bit qv[$];
  logic [31:0] qp[$];
  bit ev = 1'b0;
  bit v;
  logic [31:0] ep = '0;
  logic [31:0] pv;
  logic signed [31:0] mp;
  booth_wallace_cla #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .out_valid(out_valid),
    .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    mp = $signed(multiplicand) * $signed(multiplier);
    if (rst) begin
      seen = 1'b1;
      qv.delete();
      qp.delete();
      for (int i = 1; i < LAT; i++) begin
        qv.push_back(1'b0);
        qp.push_back('0);
      end
      ev = 1'b0;
      ep = '0;
    end else begin
      qv.push_back(in_valid);
      qp.push_back(mp);
      v = qv.pop_front();
      pv = qp.pop_front();
      ev = v;
      if (v) ep = pv;
    end
    #1;
    if (seen) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("product", product, ep);
    end
  end
  task automatic op_lit(input int a, input int b, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    multiplicand = 16'(a);
    multiplier = 16'(b);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("lit_product", product, exp);
    chk("lit_valid", {31'b0, out_valid}, 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_product", product, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    op_lit(5, 7, 32'd35);
    @(negedge clk);
    in_valid = 1'b1;
    multiplicand = 16'(3);
    multiplier = 16'(2);
    @(negedge clk);
    multiplicand = 16'(-3);
    multiplier = 16'(-2);
    @(negedge clk);
    multiplicand = 16'(-3);
    multiplier = 16'(2);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("b2b_last", product, -32'sd6);
    op_lit(3, 2, 32'd6);
    op_lit(-3, -2, 32'd6);
    op_lit(-3, 2, -32'sd6);
    op_lit(32767, 32767, 32'h3FFF_0001);
    op_lit(-32768, -32768, 32'h4000_0000);
    op_lit(-32768, 32767, -32'sd1073709056);
    op_lit(0, -32768, 32'd0);
    op_lit(100, -7, -32'sd700);
    repeat (3) @(negedge clk);
    chk("hold_product", product, -32'sd700);
    chk("hold_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    multiplicand = 16'(11);
    multiplier = 16'(13);
    @(negedge clk);
    multiplicand = 16'(17);
    multiplier = 16'(19);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_product", product, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    multiplicand = 16'(5);
    multiplier = 16'(6);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("midrst_after", product, 32'd30);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: multiplier = 16'hAAAA;
        1: multiplier = 16'h5555;
        2: multiplier = 16'h8000;
        3: multiplier = 16'h7FFF;
        default: multiplier = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: multiplicand = 16'h8000;
        1: multiplicand = 16'h7FFF;
        default: multiplicand = 16'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/booth_wallace_cla.md
Name: booth_wallace_cla

Overview:
Signed 16x16 -> 32-bit two's-complement multiplier. It uses three stages:
- radix-4 (modified) Booth recoding of the multiplier,
- Wallace-tree carry-save reduction of the partial products,
- a final carry-lookahead adder (CLA).

The result is registered at the output. It is a reusable arithmetic block in the datapath, fed by a valid-qualified operand pair and producing a valid-qualified product.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4. Product width is 2*WIDTH. All test values below assume 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- multiplicand  input  WIDTH  signed two's-complement operand A.
- multiplier  input  WIDTH  signed two's-complement operand B; this is the Booth-recoded operand.
- out_valid  output  1  product valid.
- product  output  2*WIDTH  signed A*B.

Behaviour:
- Reset: on a rising clk with rst=1, product <= 0 and out_valid <= 0. rst has priority over in_valid; an operation launched in the reset cycle is discarded.
- Booth recoding:
  - Form WIDTH/2 = 8 digits from triplets {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0.
  - Digit set {-2,-1,0,+1,+2}.
  - Each partial product is 0, ±A or ±2A, sign-extended to 2*WIDTH and shifted left by 2i.
  - Negation is done as one's complement plus a +1 correction bit injected into the tree. No separate incrementer.
- Wallace tree:
  - Reduce the 8 partial products plus the correction bits to two 2*WIDTH vectors (sum, carry) using full/half-adder (3:2) layers.
  - All arithmetic is modulo 2^(2*WIDTH).
- CLA:
  - 2*WIDTH-bit adder built from 4-bit lookahead groups with group generate/propagate. No ripple across groups beyond the group-level lookahead.
  - Carry-out is discarded.
- Latency:
  - Booth, tree and CLA are combinational.
  - product and out_valid are registered: product updates on the rising edge where in_valid=1 is sampled, so latency is 1 cycle.
  - out_valid <= in_valid every cycle.
- When in_valid=0, product holds its last value and out_valid=0 the next cycle.
- Back-to-back: in_valid may be 1 every cycle. Throughput is 1 product/cycle with no stalls. There is no ready/backpressure.
- Exactness: the result equals the full signed product for all inputs, including the extreme cases:
  - -32768*-32768 = +1073741824 (0x4000_0000). This is representable in 32 bits with no overflow.
  - -32768*32767 = -1073709056.
- Outputs never show X after the first reset.

Optional Feature:
- Macro: BOOTH_WALLACE_CLA_PIPE_EN.
- When defined: an extra register stage sits between the Wallace-tree outputs (sum, carry) and the CLA. Latency is 2 cycles and out_valid is delayed by 2. rst clears the intermediate registers and their valid bit, as well as product/out_valid. Throughput is still 1/cycle.
- When undefined: latency is 1 cycle, as described above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=5, B=7 -> product=0, out_valid=0. First valid result appears only after rst deasserts.
- Small signs, back-to-back, in_valid=1 each cycle:
  - A=3, B=2 -> product 6
  - A=-3, B=-2 -> product 6
  - A=-3, B=2 -> product -6
  - Each appears 1 cycle after issue (2 with BOOTH_WALLACE_CLA_PIPE_EN), with out_valid=1.
- Extremes:
  - A=32767, B=32767 -> 1073676289 (0x3FFF_0001)
  - A=-32768, B=-32768 -> 1073741824 (0x4000_0000)
  - A=-32768, B=32767 -> -1073709056
  - A=0, B=-32768 -> 0
- Hold: issue A=100, B=-7, then in_valid=0 for 3 cycles -> product stays -700 and out_valid falls to 0 after the latency.
- Reset mid-stream: issue 3 ops back-to-back and assert rst on the 2nd issue cycle -> in-flight results are discarded, product=0, out_valid=0. The op issued after rst deasserts completes normally.
- Random: 10,000 random signed A/B pairs with random in_valid -> product equals the reference model A*B at the correct latency. Cover all Booth digit values, including B=0xAAAA and B=0x5555.
